// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared pipeline widths, zero constants and enable encodings
package wb_regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_NUM_DEF = 2 ** ADDR_W_DEF;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [4:0] ZERO_REG_ADDR = 5'd0;
  localparam logic WRITE_EN = 1'b1;
  localparam logic READ_EN = 1'b1;
endpackage

// File: rtl/wb_regfile_array.sv
// wb_regfile_array: async-reset register storage with one write port and two raw read ports
module wb_regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_NUM = REG_NUM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] mem [REG_NUM];
  // clear everything on reset; entry 0 is never written so it stays zero
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
    else if (we == WRITE_EN && waddr != ZERO_REG_ADDR)
      mem[waddr] <= wdata;
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register plus 32x32 register file; define WB_REGFILE_BYPASS_EN for wb-to-read forwarding
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_NUM = REG_NUM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_reg_en_i,
  input  logic [ADDR_W-1:0] write_reg_addr_i,
  input  logic [DATA_W-1:0] write_reg_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              read_reg1_en_i,
  input  logic [ADDR_W-1:0] read_reg1_addr_i,
  output logic [DATA_W-1:0] read_reg1_data_o,
  input  logic              read_reg2_en_i,
  input  logic [ADDR_W-1:0] read_reg2_addr_i,
  output logic [DATA_W-1:0] read_reg2_data_o,
  output logic              wb_en_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o
);
  logic [DATA_W-1:0] raw1, raw2;
  logic hit1, hit2;
  // write-back register: flush clears, otherwise stall holds, otherwise capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_en_o <= 1'b0;
      wb_addr_o <= ZERO_REG_ADDR;
      wb_data_o <= ZERO_WORD;
    end else if (flush_i) begin
      wb_en_o <= 1'b0;
      wb_addr_o <= ZERO_REG_ADDR;
      wb_data_o <= ZERO_WORD;
    end else if (!stall_i) begin
      wb_en_o <= write_reg_en_i;
      wb_addr_o <= write_reg_addr_i;
      wb_data_o <= write_reg_data_i;
    end
  wb_regfile_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) u_array (
    .clk(clk),
    .rst(rst),
    .we(wb_en_o),
    .waddr(wb_addr_o),
    .wdata(wb_data_o),
    .raddr1(read_reg1_addr_i),
    .rdata1(raw1),
    .raddr2(read_reg2_addr_i),
    .rdata2(raw2)
  );
`ifdef WB_REGFILE_BYPASS_EN
  assign hit1 = wb_en_o == WRITE_EN && wb_addr_o != ZERO_REG_ADDR && wb_addr_o == read_reg1_addr_i;
  assign hit2 = wb_en_o == WRITE_EN && wb_addr_o != ZERO_REG_ADDR && wb_addr_o == read_reg2_addr_i;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  // read ports: reset, disabled and r0 reads return zero; then bypass, then array
  always_comb begin
    read_reg1_data_o = (rst || read_reg1_en_i != READ_EN || read_reg1_addr_i == ZERO_REG_ADDR) ? ZERO_WORD :
                       hit1 ? wb_data_o : raw1;
    read_reg2_data_o = (rst || read_reg2_en_i != READ_EN || read_reg2_addr_i == ZERO_REG_ADDR) ? ZERO_WORD :
                       hit2 ? wb_data_o : raw2;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile against a spec-level register file model
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, st = 1'b0, fl = 1'b0, r1e = 1'b0, r2e = 1'b0;
  logic [4:0]  wa = '0, r1a = '0, r2a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd1, rd2, wbd;
  logic        wbe;
  logic [4:0]  wba;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .write_reg_en_i(we), .write_reg_addr_i(wa), .write_reg_data_i(wd),
    .stall_i(st), .flush_i(fl),
    .read_reg1_en_i(r1e), .read_reg1_addr_i(r1a), .read_reg1_data_o(rd1),
    .read_reg2_en_i(r2e), .read_reg2_addr_i(r2a), .read_reg2_data_o(rd2),
    .wb_en_o(wbe), .wb_addr_o(wba), .wb_data_o(wbd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        q[$];
  event        sample;
  int          checks = 0, errors = 0;
  logic [31:0] mem [32];
  logic        m_en;
  logic [4:0]  m_a;
  logic [31:0] m_d;

  function automatic logic [31:0] mread(input logic e, input logic [4:0] a);
    if (!e || a == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
    if (m_en && m_a == a) return m_d;
`endif
    return mem[a];
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    m_en = 1'b0;
    m_a = 5'd0;
    m_d = 32'h0;
  endtask

  task automatic cyc(input logic iwe, input logic [4:0] iwa, input logic [31:0] iwd,
                     input logic ist, input logic ifl,
                     input logic i1e, input logic [4:0] i1a, input logic i2e, input logic [4:0] i2a);
    @(negedge clk);
    we = iwe; wa = iwa; wd = iwd; st = ist; fl = ifl;
    r1e = i1e; r1a = i1a; r2e = i2e; r2a = i2a;
    q.push_back('{mread(i1e, i1a), mread(i2e, i2a), m_en, m_a, m_d});
    ->sample;
    @(posedge clk);
    if (m_en && m_a != 5'd0) mem[m_a] = m_d;
    if (ifl) begin
      m_en = 1'b0; m_a = 5'd0; m_d = 32'h0;
    end else if (!ist) begin
      m_en = iwe; m_a = iwa; m_d = iwd;
    end
  endtask

  // monitor: every presented cycle is compared against the queued expectation
  initial forever begin
    exp_t e;
    @(sample);
    #1;
    if (q.size() == 0) begin
      chk("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("rd1", rd1, e.r1);
      chk("rd2", rd2, e.r2);
      chk("wb_en", {31'd0, wbe}, {31'd0, e.en});
      chk("wb_addr", {27'd0, wba}, {27'd0, e.a});
      chk("wb_data", wbd, e.d);
    end
  end

  initial begin
    model_reset();
    #1;
    chk("reset_wb_en", {31'd0, wbe}, 32'd0);
    chk("reset_wb_data", wbd, 32'd0);
    chk("reset_rd1", rd1, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // basic write then read, with port 2 disabled on the last read
    cyc(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 5'd0, 0, 5'd0);
    cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd3, 1, 5'd3);
    cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd3, 0, 5'd3);
    chk("r3_committed", mem[3], 32'hDEADBEEF);
    // r0 write is discarded on both ports
    cyc(1, 5'd0, 32'hFFFFFFFF, 0, 0, 1, 5'd0, 1, 5'd0);
    for (int i = 0; i < 3; i++) cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd0, 1, 5'd0);
    // read-after-write distance on r7
    cyc(1, 5'd7, 32'hA5A5A5A5, 0, 0, 0, 5'd0, 0, 5'd0);
    cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd7, 1, 5'd7);
    cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd7, 1, 5'd7);
    // capture r9=0x11, then stall while the input changes
    cyc(1, 5'd9, 32'h11, 0, 0, 0, 5'd0, 0, 5'd0);
    for (int i = 0; i < 3; i++) cyc(1, 5'd9, 32'h22, 1, 0, 1, 5'd9, 1, 5'd9);
    cyc(1, 5'd9, 32'h22, 1, 1, 1, 5'd9, 1, 5'd9);
    cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd9, 1, 5'd9);
    chk("r9_after_stall", mem[9], 32'h11);
    // back-to-back writes to r4
    cyc(1, 5'd4, 32'h1, 0, 0, 0, 5'd0, 0, 5'd0);
    cyc(1, 5'd4, 32'h2, 0, 0, 1, 5'd4, 1, 5'd4);
    cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd4, 1, 5'd4);
    cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd4, 1, 5'd4);
    // asynchronous reset mid-cycle wipes the held request and the array
    cyc(1, 5'd5, 32'h1234, 0, 0, 0, 5'd0, 0, 5'd0);
    cyc(1, 5'd5, 32'h1234, 1, 0, 1, 5'd5, 1, 5'd5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wb_en", {31'd0, wbe}, 32'd0);
    chk("async_rst_rd1", rd1, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 5'd0, 32'h0, 0, 0, 1, 5'd5, 1, 5'd5);
    // randomized traffic over a narrow address range to provoke hazards
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)),
          $urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)));
    @(negedge clk);
    #3;
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
